down_counter_slice: RTL and testbench



---
 rtl/down_counter_slice.sv | 38 +++
 tb/tb_down_counter_slice.sv | 99 +++++++++
 2 files changed

// File: rtl/down_counter_slice.sv
// down_counter_slice: cascadable down-counter slice with borrow chain; DOWN_COUNTER_SLICE_AUTORELOAD_EN adds an auto-reload register
module down_counter_slice #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  output logic             tc
);
  logic [WIDTH-1:0] wrap;
  logic dec, zero;
`ifdef DOWN_COUNTER_SLICE_AUTORELOAD_EN
  logic [WIDTH-1:0] rld;
  always_ff @(posedge clk or posedge rst)
    if (rst) rld <= '0;
    else if (clr_n && !load_n) rld <= d;
  assign wrap = rld;
`else
  assign wrap = '1;
`endif
  assign dec  = enp & ent;
  assign zero = q == '0;
  assign bo   = ent & zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= !clr_n ? '0 : !load_n ? d : !dec ? q : zero ? wrap : q - 1'b1;
      tc <= clr_n & load_n & dec & zero;
    end
endmodule

// File: tb/tb_down_counter_slice.sv
// tb_down_counter_slice: random and directed checks of a single slice and a two-slice cascade against an arithmetic model
module tb_down_counter_slice;
  logic clk = 1'b0, rst = 1'b1, clr_n = 1'b1, load_n = 1'b1, enp = 1'b0, ent = 1'b0, c_ent = 1'b0;
  logic [3:0] d = '0, q, q_lo, q_hi;
  logic [7:0] dc = '0;
  logic bo, tc, bo_lo, bo_hi, tc_lo, tc_hi;
  int total = 0, bad = 0;
  int mq = 0, mr = 0, mt = 0, mc = 0;
  always #5 clk = ~clk;
  down_counter_slice #(.WIDTH(4)) u0 (.clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(ent), .d(d), .q(q), .bo(bo), .tc(tc));
  down_counter_slice #(.WIDTH(4)) u_lo (.clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(c_ent), .d(dc[3:0]), .q(q_lo), .bo(bo_lo), .tc(tc_lo));
  down_counter_slice #(.WIDTH(4)) u_hi (.clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(bo_lo), .d(dc[7:4]), .q(q_hi), .bo(bo_hi), .tc(tc_hi));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_slice(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".tc"}, 32'(tc), 32'(mt));
    chk({tag, ".bo"}, 32'(bo), 32'(ent && mq == 0));
`ifndef DOWN_COUNTER_SLICE_AUTORELOAD_EN
    chk({tag, ".casc"}, 32'({q_hi, q_lo}), 32'(mc));
`endif
  endtask
  task automatic cyc(input logic c, input logic l, input logic p, input logic t, input logic [3:0] dv,
                     input logic ct, input logic [7:0] dcv, input string tag);
    int w;
    clr_n = c; load_n = l; enp = p; ent = t; d = dv; c_ent = ct; dc = dcv;
    @(posedge clk);
`ifdef DOWN_COUNTER_SLICE_AUTORELOAD_EN
    w = mr;
`else
    w = 15;
`endif
    mt = 0;
    if (!c) mq = 0;
    else if (!l) begin mq = int'(dv); mr = int'(dv); end
    else if (p && t) begin mt = int'(mq == 0); mq = mq == 0 ? w : mq - 1; end
    if (!c) mc = 0;
    else if (!l) mc = int'(dcv);
    else if (p && ct) mc = (mc + 255) % 256;
    #1;
    chk_slice(tag);
  endtask
  initial begin
    ent = 1'b1;
    #12;
    chk("rst.q", 32'(q), 0);
    chk("rst.tc", 32'(tc), 0);
    chk("rst.bo_ent1", 32'(bo), 1);
    ent = 1'b0;
    #1;
    chk("rst.bo_ent0", 32'(bo), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0, 4'd5, 0, 8'h00, "load5");
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 1, 4'd0, 0, 8'h00, "count");
    cyc(0, 0, 0, 0, 4'd9, 0, 8'h00, "clr_vs_load");
    chk("clr_vs_load.q0", 32'(q), 0);
    cyc(1, 0, 0, 0, 4'd9, 0, 8'h00, "load9");
    chk("load9.q9", 32'(q), 9);
    cyc(1, 1, 1, 0, 4'd0, 0, 8'h00, "hold_ent0");
    chk("hold_ent0.q9", 32'(q), 9);
    cyc(0, 1, 0, 1, 4'd0, 0, 8'h00, "clr");
    cyc(1, 1, 0, 1, 4'd0, 0, 8'h00, "bo_enp0");
    chk("bo_enp0.bo", 32'(bo), 1);
    ent = 1'b0;
    #1;
    chk("bo_gate.bo", 32'(bo), 0);
    cyc(1, 0, 0, 0, 4'd0, 0, 8'h10, "casc_load");
    cyc(1, 1, 1, 0, 4'd0, 1, 8'h00, "casc_dec1");
    cyc(1, 1, 1, 0, 4'd0, 1, 8'h00, "casc_dec2");
`ifndef DOWN_COUNTER_SLICE_AUTORELOAD_EN
    chk("casc.0e", 32'({q_hi, q_lo}), 32'h0e);
`endif
    for (int i = 0; i < 300; i++)
      cyc(logic'($urandom_range(15) != 0), logic'($urandom_range(7) != 0), logic'($urandom_range(3) != 0),
          logic'($urandom_range(3) != 0), 4'($urandom), logic'($urandom_range(3) != 0), 8'($urandom), "rand");
    cyc(1, 0, 0, 0, 4'd7, 0, 8'h33, "pre_async");
    #2;
    rst = 1'b1;
    #1;
    chk("async.q", 32'(q), 0);
    chk("async.tc", 32'(tc), 0);
    chk("async.casc", 32'({q_hi, q_lo}), 0);
    mq = 0; mr = 0; mt = 0; mc = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 1, 1, 4'd0, 1, 8'h00, "after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
